cmsdk_ahb_to_apb_async_apb_if: RTL and testbench

CMSDK_AHB_TO_APB_ASYNC_APB_IF -- requirements
Module: cmsdk_ahb_to_apb_async_apb_if

---
 rtl/cmsdk_ahb_to_apb_async_apb_if_pkg.sv | 21 ++
 rtl/cmsdk_ahb_to_apb_async_syn.sv | 26 ++
 rtl/cmsdk_ahb_to_apb_async_apb_if.sv | 148 ++++++++++++++
 tb/tb_cmsdk_ahb_to_apb_async_apb_if.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cmsdk_ahb_to_apb_async_apb_if_pkg.sv
// Shared types and widths for the APB side of the AHB-to-APB async bridge.
// Holds the FSM encoding, the APB field widths and the strobe helper.
package cmsdk_ahb_to_apb_async_apb_if_pkg;

  localparam int APB_DATA_W = 32;
  localparam int APB_STRB_W = 4;
  localparam int APB_PROT_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } apb_state_e;

  // Reads never present byte strobes on the bus.
  function automatic logic [APB_STRB_W-1:0] apb_strb(input logic                  write,
                                                     input logic [APB_STRB_W-1:0] strb);
    return write ? strb : '0;
  endfunction

endpackage

// File: rtl/cmsdk_ahb_to_apb_async_syn.sv
// Two-flop synchronizer for a single level/toggle signal crossing into clk.
// The enable is normally tied high; it only gates both stages together.
module cmsdk_ahb_to_apb_async_syn (
  input  logic clk,
  input  logic resetn,
  input  logic en_i,
  input  logic d_i,
  output logic q_o
);

  logic sync1_q;
  logic sync2_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else if (en_i) begin
      sync1_q <= d_i;
      sync2_q <= sync1_q;
    end
  end

  assign q_o = sync2_q;

endmodule

// File: rtl/cmsdk_ahb_to_apb_async_apb_if.sv
// APB-domain half of the async AHB-to-APB bridge: turns a synchronized request
// toggle into one APB transfer and answers with an ack toggle plus response.
module cmsdk_ahb_to_apb_async_apb_if
  import cmsdk_ahb_to_apb_async_apb_if_pkg::*;
#(
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  req_tog,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic                  req_write,
  input  logic [APB_DATA_W-1:0] req_wdata,
  input  logic [APB_STRB_W-1:0] req_strb,
  input  logic [APB_PROT_W-1:0] req_prot,
  output logic                  ack_tog,
  output logic [APB_DATA_W-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic [APB_DATA_W-1:0] PWDATA,
  output logic [APB_STRB_W-1:0] PSTRB,
  output logic [APB_PROT_W-1:0] PPROT,
  input  logic                  PREADY,
  input  logic [APB_DATA_W-1:0] PRDATA,
  input  logic                  PSLVERR
);

  logic req_sync;

  cmsdk_ahb_to_apb_async_syn u_req_syn (
    .clk    (clk),
    .resetn (resetn),
    .en_i   (1'b1),
    .d_i    (req_tog),
    .q_o    (req_sync)
  );

  apb_state_e            state_q,    state_d;
  logic                  req_seen_q, req_seen_d;
  logic                  ack_tog_q,  ack_tog_d;
  logic [APB_DATA_W-1:0] rdata_q,    rdata_d;
  logic                  err_q,      err_d;
  logic                  psel_q,     psel_d;
  logic                  penable_q,  penable_d;
  logic                  pwrite_q,   pwrite_d;
  logic [ADDR_WIDTH-1:0] paddr_q,    paddr_d;
  logic [APB_DATA_W-1:0] pwdata_q,   pwdata_d;
  logic [APB_STRB_W-1:0] pstrb_q,    pstrb_d;
  logic [APB_PROT_W-1:0] pprot_q,    pprot_d;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= ST_IDLE;
      req_seen_q <= 1'b0;
      ack_tog_q  <= 1'b0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
      psel_q     <= 1'b0;
      penable_q  <= 1'b0;
      pwrite_q   <= 1'b0;
      paddr_q    <= '0;
      pwdata_q   <= '0;
      pstrb_q    <= '0;
      pprot_q    <= '0;
    end else begin
      state_q    <= state_d;
      req_seen_q <= req_seen_d;
      ack_tog_q  <= ack_tog_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
      psel_q     <= psel_d;
      penable_q  <= penable_d;
      pwrite_q   <= pwrite_d;
      paddr_q    <= paddr_d;
      pwdata_q   <= pwdata_d;
      pstrb_q    <= pstrb_d;
      pprot_q    <= pprot_d;
    end
  end

  // The request fields are only sampled on the IDLE->SETUP step, so the bus
  // keeps the last transfer's values whenever PSEL is low.
  always_comb begin
    state_d    = state_q;
    req_seen_d = req_seen_q;
    ack_tog_d  = ack_tog_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    psel_d     = psel_q;
    penable_d  = penable_q;
    pwrite_d   = pwrite_q;
    paddr_d    = paddr_q;
    pwdata_d   = pwdata_q;
    pstrb_d    = pstrb_q;
    pprot_d    = pprot_q;

    case (state_q)
      ST_IDLE: begin
        if (req_sync != req_seen_q) begin
          state_d  = ST_SETUP;
          psel_d   = 1'b1;
          pwrite_d = req_write;
          paddr_d  = req_addr;
          pwdata_d = req_wdata;
          pstrb_d  = apb_strb(req_write, req_strb);
          pprot_d  = req_prot;
        end
      end
      ST_SETUP: begin
        state_d   = ST_ACCESS;
        penable_d = 1'b1;
      end
      ST_ACCESS: begin
        if (PREADY) begin
          if (!pwrite_q) begin
            rdata_d = PRDATA;
          end
          err_d      = PSLVERR;
          ack_tog_d  = ~ack_tog_q;
          req_seen_d = req_sync;
          psel_d     = 1'b0;
          penable_d  = 1'b0;
          state_d    = ST_IDLE;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        psel_d    = 1'b0;
        penable_d = 1'b0;
      end
    endcase
  end

  assign ack_tog   = ack_tog_q;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign PSEL      = psel_q;
  assign PENABLE   = penable_q;
  assign PWRITE    = pwrite_q;
  assign PADDR     = paddr_q;
  assign PWDATA    = pwdata_q;
  assign PSTRB     = pstrb_q;
  assign PPROT     = pprot_q;

endmodule

// File: tb/tb_cmsdk_ahb_to_apb_async_apb_if.sv
// Scoreboard bench for the APB-side bridge half: stimulus pushes expected bus
// fields and responses, a slave model and an ack monitor pop and compare.
module tb_cmsdk_ahb_to_apb_async_apb_if;

  logic        clk = 1'b0;
  logic        resetn;
  logic        req_tog;
  logic [15:0] req_addr;
  logic        req_write;
  logic [31:0] req_wdata;
  logic [3:0]  req_strb;
  logic [2:0]  req_prot;
  logic        ack_tog;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        PSEL, PENABLE, PWRITE;
  logic [15:0] PADDR;
  logic [31:0] PWDATA;
  logic [3:0]  PSTRB;
  logic [2:0]  PPROT;
  logic        PREADY;
  logic [31:0] PRDATA;
  logic        PSLVERR;

  cmsdk_ahb_to_apb_async_apb_if #(.ADDR_WIDTH(16)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .req_tog   (req_tog),
    .req_addr  (req_addr),
    .req_write (req_write),
    .req_wdata (req_wdata),
    .req_strb  (req_strb),
    .req_prot  (req_prot),
    .ack_tog   (ack_tog),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .PSEL      (PSEL),
    .PENABLE   (PENABLE),
    .PWRITE    (PWRITE),
    .PADDR     (PADDR),
    .PWDATA    (PWDATA),
    .PSTRB     (PSTRB),
    .PPROT     (PPROT),
    .PREADY    (PREADY),
    .PRDATA    (PRDATA),
    .PSLVERR   (PSLVERR)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [2:0]  prot;
  } apb_exp_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } rsp_exp_t;

  apb_exp_t apb_q[$];
  rsp_exp_t rsp_q[$];

  int n_checks = 0;
  int n_pass   = 0;

  int          slave_wait  = 0;
  logic [31:0] slave_rdata = '0;
  logic        slave_err   = 1'b0;
  logic [31:0] model_rdata = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Slave model plus bus-side scoreboard: fields are checked on the cycle PREADY rises.
  initial begin
    int cnt;
    apb_exp_t a;
    cnt     = 0;
    PREADY  = 1'b0;
    PRDATA  = '0;
    PSLVERR = 1'b0;
    forever begin
      @(negedge clk);
      PRDATA  = slave_rdata;
      PSLVERR = slave_err;
      if (!resetn || !PSEL) begin
        PREADY = 1'b0;
      end else if (!PENABLE) begin
        cnt    = slave_wait;
        PREADY = 1'b0;
      end else if (cnt > 0) begin
        cnt--;
        PREADY = 1'b0;
      end else if (!PREADY) begin
        PREADY = 1'b1;
        if (apb_q.size() == 0) begin
          n_checks++;
          $display("FAIL apb_unexpected: transfer at PADDR %h with no expectation", PADDR);
        end else begin
          a = apb_q.pop_front();
          check("PADDR",  32'(PADDR),  32'(a.addr));
          check("PWRITE", 32'(PWRITE), 32'(a.write));
          check("PWDATA", PWDATA,      a.wdata);
          check("PSTRB",  32'(PSTRB),  32'(a.strb));
          check("PPROT",  32'(PPROT),  32'(a.prot));
        end
      end
    end
  end

  // Response scoreboard: one pop per ack_tog edge.
  initial begin
    logic     ack_prev;
    rsp_exp_t r;
    ack_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        ack_prev = 1'b0;
      end else if (ack_tog != ack_prev) begin
        ack_prev = ack_tog;
        if (rsp_q.size() == 0) begin
          n_checks++;
          $display("FAIL ack_unexpected: ack_tog %b with no expectation", ack_tog);
        end else begin
          r = rsp_q.pop_front();
          check("rsp_rdata", rsp_rdata,      r.rdata);
          check("rsp_err",   32'(rsp_err),   32'(r.err));
        end
      end
    end
  end

  // Entered at a negedge; toggles req_tog there so the next posedge is E0.
  task automatic xfer(input logic [15:0] addr, input logic wr, input logic [31:0] wdata,
                      input logic [3:0] strb, input logic [2:0] prot, input int waits,
                      input logic [31:0] rdata, input logic err);
    apb_exp_t a;
    rsp_exp_t r;
    int psel_at, pen_at, ack_at, pen_cnt;
    slave_wait  = waits;
    slave_rdata = rdata;
    slave_err   = err;
    req_addr    = addr;
    req_write   = wr;
    req_wdata   = wdata;
    req_strb    = strb;
    req_prot    = prot;
    a.addr  = addr;
    a.write = wr;
    a.wdata = wdata;
    a.strb  = wr ? strb : 4'h0;
    a.prot  = prot;
    apb_q.push_back(a);
    if (!wr) model_rdata = rdata;
    r.rdata = model_rdata;
    r.err   = err;
    rsp_q.push_back(r);
    req_tog = ~req_tog;
    psel_at = -1;
    pen_at  = -1;
    ack_at  = -1;
    pen_cnt = 0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (PSEL && psel_at < 0) psel_at = k;
      if (PENABLE) begin
        if (pen_at < 0) pen_at = k;
        pen_cnt++;
      end
      if (ack_tog == req_tog) begin
        ack_at = k;
        break;
      end
    end
    if (ack_at < 0) begin
      n_checks++;
      $display("FAIL ack_timeout: ack_tog %b never reached req_tog %b", ack_tog, req_tog);
    end else begin
      check("psel_latency",    32'(psel_at), 32'd3);
      check("penable_latency", 32'(pen_at),  32'd4);
      check("ack_latency",     32'(ack_at),  32'(5 + waits));
      check("penable_cycles",  32'(pen_cnt), 32'(waits + 1));
      check("idle_after_ack",  32'(PSEL),    32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn    = 1'b0;
    req_tog   = 1'b0;
    req_addr  = '0;
    req_write = 1'b0;
    req_wdata = '0;
    req_strb  = '0;
    req_prot  = '0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    check("rst_PSEL",      32'(PSEL),    32'd0);
    check("rst_PENABLE",   32'(PENABLE), 32'd0);
    check("rst_PWRITE",    32'(PWRITE),  32'd0);
    check("rst_PADDR",     32'(PADDR),   32'd0);
    check("rst_PWDATA",    PWDATA,       32'd0);
    check("rst_PSTRB",     32'(PSTRB),   32'd0);
    check("rst_PPROT",     32'(PPROT),   32'd0);
    check("rst_ack_tog",   32'(ack_tog), 32'd0);
    check("rst_rsp_rdata", rsp_rdata,    32'd0);
    check("rst_rsp_err",   32'(rsp_err), 32'd0);

    // addr, write, wdata, strb, prot, waits, slave rdata, slave err
    xfer(16'h0010, 1'b1, 32'hA5A5_0001, 4'hF, 3'b000, 0, 32'h0000_0000, 1'b0);
    check("ack_parity_1", 32'(ack_tog), 32'd1);
    repeat (2) @(negedge clk);
    check("hold_PWDATA", PWDATA, 32'hA5A5_0001);
    xfer(16'h0024, 1'b0, 32'hCAFE_0000, 4'hF, 3'b010, 3, 32'h1234_5678, 1'b0);
    repeat (2) @(negedge clk);
    xfer(16'h0030, 1'b0, 32'h0000_0000, 4'h0, 3'b001, 1, 32'hDEAD_BEEF, 1'b1);
    repeat (2) @(negedge clk);
    xfer(16'h0040, 1'b1, 32'h0BAD_F00D, 4'h3, 3'b100, 0, 32'hFFFF_FFFF, 1'b0);
    check("rdata_kept_on_write", rsp_rdata, 32'hDEAD_BEEF);

    // Back-to-back: each request toggled on the negedge that sees the ack.
    xfer(16'h0100, 1'b1, 32'h1111_2222, 4'h5, 3'b001, 0, 32'h0000_0000, 1'b0);
    check("b2b_parity_1", 32'(ack_tog), 32'(req_tog));
    xfer(16'h0104, 1'b0, 32'h0000_0000, 4'hF, 3'b000, 0, 32'h3333_4444, 1'b0);
    check("b2b_parity_2", 32'(ack_tog), 32'(req_tog));
    xfer(16'h0108, 1'b1, 32'h5555_6666, 4'h8, 3'b111, 2, 32'h0000_0000, 1'b0);
    check("b2b_parity_3", 32'(ack_tog), 32'(req_tog));

    // Abort in ACCESS: slave holds PREADY low, reset lands mid-cycle.
    repeat (2) @(negedge clk);
    slave_wait  = 20;
    slave_rdata = 32'h9999_9999;
    slave_err   = 1'b0;
    req_addr    = 16'h0300;
    req_write   = 1'b0;
    req_tog     = ~req_tog;
    for (int k = 0; k < 20 && !PENABLE; k++) @(negedge clk);
    check("abort_in_access", 32'(PENABLE), 32'd1);
    #2;
    resetn  = 1'b0;
    req_tog = 1'b0;
    #1;
    check("abort_PSEL",      32'(PSEL),    32'd0);
    check("abort_PENABLE",   32'(PENABLE), 32'd0);
    check("abort_ack_tog",   32'(ack_tog), 32'd0);
    check("abort_PADDR",     32'(PADDR),   32'd0);
    check("abort_rsp_rdata", rsp_rdata,    32'd0);
    check("abort_rsp_err",   32'(rsp_err), 32'd0);
    model_rdata = '0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    xfer(16'h0200, 1'b0, 32'h0000_0000, 4'hF, 3'b000, 0, 32'h7777_8888, 1'b0);
    check("post_reset_ack", 32'(ack_tog), 32'd1);

    repeat (5) @(negedge clk);
    check("apb_q_drained", 32'(apb_q.size()), 32'd0);
    check("rsp_q_drained", 32'(rsp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
